// File: rtl/camara_pkg.sv
// Shared types and constants for the OV7670 + AL422 FIFO capture/readout path.
package camara_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StWrst,
        StCapture,
        StStored,
        StRrst,
        StRead
    } state_e;

    localparam int unsigned DefHRes      = 160;
    localparam int unsigned DefVRes      = 120;
    localparam int unsigned DefBppBytes  = 2;
    localparam int unsigned DefRdDiv     = 2;
    localparam int unsigned DefRrstClks  = 2;

    // AL422 control pins are all active low.
    localparam logic FifoActive = 1'b0;
    localparam logic FifoIdle   = 1'b1;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/camara_rdclk_gen.sv
// FIFO read-clock divider: 50% duty rdclk of 2*RD_DIV clk cycles, plus a strobe
// that is high in the cycle whose closing edge drives rdclk low.
module camara_rdclk_gen
    import camara_pkg::*;
#(
    parameter int unsigned RD_DIV = DefRdDiv
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic clr_i,
    output logic rdclk_o,
    output logic fall_o
);

    localparam int unsigned CW = clog2_min1(RD_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          rdclk_q, rdclk_d;

    always_comb begin
        cnt_d   = cnt_q;
        rdclk_d = rdclk_q;
        fall_o  = 1'b0;
        if (clr_i) begin
            cnt_d   = '0;
            rdclk_d = 1'b0;
        end else if (en_i) begin
            if (cnt_q == CW'(RD_DIV - 1)) begin
                cnt_d   = '0;
                rdclk_d = ~rdclk_q;
                fall_o  = rdclk_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            rdclk_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rdclk_q <= rdclk_d;
        end
    end

    assign rdclk_o = rdclk_q;

endmodule

// File: rtl/camara_fifo_reader.sv
// Frame capture into an AL422 FIFO bounded by VSYNC, then paced readout that
// assembles pixels with valid strobe and x/y coordinates.
module camara_fifo_reader
    import camara_pkg::*;
#(
    parameter int unsigned H_RES     = DefHRes,
    parameter int unsigned V_RES     = DefVRes,
    parameter int unsigned BPP_BYTES = DefBppBytes,
    parameter int unsigned RD_DIV    = DefRdDiv,
    parameter int unsigned RRST_CLKS = DefRrstClks,
    localparam int unsigned XW       = clog2_min1(H_RES),
    localparam int unsigned YW       = clog2_min1(V_RES),
    localparam int unsigned PW       = 8 * BPP_BYTES
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          takepicture_i,
    input  logic          leer_i,
    input  logic          vsync_i,
    input  logic [7:0]    din_i,
    output logic          we_o,
    output logic          wrst_o,
    output logic          rrst_o,
    output logic          oe_o,
    output logic          rdclk_o,
    output logic [PW-1:0] pix_data_o,
    output logic          pix_valid_o,
    output logic [XW-1:0] pix_x_o,
    output logic [YW-1:0] pix_y_o,
    output logic          frame_ready_o,
    output logic          frame_done_o,
    output logic          busy_o,
    output logic          led_o
);

    localparam int unsigned BW = clog2_min1(BPP_BYTES);
    localparam int unsigned RW = clog2_min1(RRST_CLKS);

    state_e state_q, state_d;

    // vs_q[0..1] synchroniser, vs_q[2] previous synchronised value
    logic [2:0]    vs_q;
    logic          vs_rise, vs_fall;

    logic [RW-1:0] rrst_cnt_q, rrst_cnt_d;
    logic [BW-1:0] byte_cnt_q, byte_cnt_d;
    logic [PW-1:0] sh_q, sh_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          last_q, last_d;
    logic          end_q, end_d;
    logic          fin_q, fin_d;

    logic          we_q, we_d;
    logic          wrst_q, wrst_d;
    logic          rrst_q, rrst_d;
    logic          oe_q, oe_d;
    logic [PW-1:0] pix_data_q, pix_data_d;
    logic          pix_valid_q, pix_valid_d;
    logic [XW-1:0] pix_x_q, pix_x_d;
    logic [YW-1:0] pix_y_q, pix_y_d;
    logic          frame_ready_q, frame_ready_d;
    logic          frame_done_q, frame_done_d;
    logic          busy_q, busy_d;
    logic          led_q, led_d;

    logic          rd_active, rd_en, rd_clr, rd_fall;

    assign vs_rise   = vs_q[1] & ~vs_q[2];
    assign vs_fall   = ~vs_q[1] & vs_q[2];
    assign rd_active = (state_q == StRrst) || (state_q == StRead);
    // Stop the read clock once the final byte of the frame is latched.
    assign rd_en     = rd_active && !end_q;
    assign rd_clr    = !rd_active;

    camara_rdclk_gen #(
        .RD_DIV (RD_DIV)
    ) u_rdclk_gen (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (rd_en),
        .clr_i   (rd_clr),
        .rdclk_o (rdclk_o),
        .fall_o  (rd_fall)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (takepicture_i) state_d = StArm;
            StArm:     if (vs_rise) state_d = StWrst;
            StWrst:    if (vs_fall) state_d = StCapture;
            StCapture: if (vs_rise) state_d = StStored;
            StStored: begin
                if (leer_i) begin
                    state_d = StRrst;
                end else if (takepicture_i) begin
                    state_d = StArm;
                end
            end
            StRrst: begin
                if (rd_fall && rrst_cnt_q == RW'(RRST_CLKS - 1)) state_d = StRead;
            end
            StRead:    if (fin_q) state_d = StStored;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        rrst_cnt_d   = '0;
        byte_cnt_d   = '0;
        sh_d         = '0;
        x_d          = '0;
        y_d          = '0;
        last_d       = 1'b0;
        end_d        = 1'b0;
        fin_d        = 1'b0;
        pix_data_d   = pix_data_q;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        frame_done_d = 1'b0;

        if (state_q == StRrst) begin
            rrst_cnt_d = rd_fall ? rrst_cnt_q + 1'b1 : rrst_cnt_q;
        end

        if (state_q == StRead) begin
            byte_cnt_d   = byte_cnt_q;
            sh_d         = sh_q;
            x_d          = x_q;
            y_d          = y_q;
            end_d        = end_q;
            frame_done_d = fin_q;
            if (rd_fall) begin
                sh_d   = (sh_q << 8) | PW'(din_i);
                last_d = (byte_cnt_q == BW'(BPP_BYTES - 1));
                byte_cnt_d = last_d ? '0 : byte_cnt_q + 1'b1;
                if (last_d && x_q == XW'(H_RES - 1) && y_q == YW'(V_RES - 1)) begin
                    end_d = 1'b1;
                end
            end
            // Pixel is published one clk after its final byte is latched.
            if (last_q) begin
                pix_valid_d = 1'b1;
                pix_data_d  = sh_q;
                pix_x_d     = x_q;
                pix_y_d     = y_q;
                fin_d       = end_q;
                if (x_q == XW'(H_RES - 1)) begin
                    x_d = '0;
                    y_d = (y_q == YW'(V_RES - 1)) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
        end

        we_d          = (state_d == StCapture) ? FifoActive : FifoIdle;
        wrst_d        = (state_d == StWrst)    ? FifoActive : FifoIdle;
        rrst_d        = (state_d == StRrst)    ? FifoActive : FifoIdle;
        oe_d          = (state_d == StRead)    ? FifoActive : FifoIdle;
        frame_ready_d = (state_d == StStored) || (state_d == StRrst) || (state_d == StRead);
        busy_d        = !((state_d == StIdle) || (state_d == StStored));
        led_d         = (state_d == StCapture);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            vs_q          <= '0;
            rrst_cnt_q    <= '0;
            byte_cnt_q    <= '0;
            sh_q          <= '0;
            x_q           <= '0;
            y_q           <= '0;
            last_q        <= 1'b0;
            end_q         <= 1'b0;
            fin_q         <= 1'b0;
            we_q          <= FifoIdle;
            wrst_q        <= FifoIdle;
            rrst_q        <= FifoIdle;
            oe_q          <= FifoIdle;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_ready_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            led_q         <= 1'b1;
        end else begin
            state_q       <= state_d;
            vs_q          <= {vs_q[1:0], vsync_i};
            rrst_cnt_q    <= rrst_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            sh_q          <= sh_d;
            x_q           <= x_d;
            y_q           <= y_d;
            last_q        <= last_d;
            end_q         <= end_d;
            fin_q         <= fin_d;
            we_q          <= we_d;
            wrst_q        <= wrst_d;
            rrst_q        <= rrst_d;
            oe_q          <= oe_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_ready_q <= frame_ready_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            led_q         <= led_d;
        end
    end

    assign we_o          = we_q;
    assign wrst_o        = wrst_q;
    assign rrst_o        = rrst_q;
    assign oe_o          = oe_q;
    assign pix_data_o    = pix_data_q;
    assign pix_valid_o   = pix_valid_q;
    assign pix_x_o       = pix_x_q;
    assign pix_y_o       = pix_y_q;
    assign frame_ready_o = frame_ready_q;
    assign frame_done_o  = frame_done_q;
    assign busy_o        = busy_q;
    assign led_o         = led_q;

endmodule

// File: tb/tb_camara_fifo_reader.sv
// Directed bench: 4x2 frame, RGB565 instance (dut0) and 1-byte instance (dut1).
module tb_camara_fifo_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic vsync = 1'b0;
    logic tp0 = 1'b0, leer0 = 1'b0, tp1 = 1'b0, leer1 = 1'b0;
    logic [7:0] din0 = 8'h00, din1 = 8'h00;

    logic        we0, wrst0, rrst0, oe0, rdclk0, pv0, fr0, fd0, busy0, led0;
    logic [15:0] pd0;
    logic [1:0]  px0;
    logic [0:0]  py0;
    logic        we1, wrst1, rrst1, oe1, rdclk1, pv1, fr1, fd1, busy1, led1;
    logic [7:0]  pd1;
    logic [1:0]  px1;
    logic [0:0]  py1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    camara_fifo_reader #(
        .H_RES(4), .V_RES(2), .BPP_BYTES(2), .RD_DIV(2), .RRST_CLKS(2)
    ) dut0 (
        .clk_i(clk), .reset_i(reset), .takepicture_i(tp0), .leer_i(leer0),
        .vsync_i(vsync), .din_i(din0), .we_o(we0), .wrst_o(wrst0), .rrst_o(rrst0),
        .oe_o(oe0), .rdclk_o(rdclk0), .pix_data_o(pd0), .pix_valid_o(pv0),
        .pix_x_o(px0), .pix_y_o(py0), .frame_ready_o(fr0), .frame_done_o(fd0),
        .busy_o(busy0), .led_o(led0)
    );

    camara_fifo_reader #(
        .H_RES(4), .V_RES(2), .BPP_BYTES(1), .RD_DIV(2), .RRST_CLKS(2)
    ) dut1 (
        .clk_i(clk), .reset_i(reset), .takepicture_i(tp1), .leer_i(leer1),
        .vsync_i(vsync), .din_i(din1), .we_o(we1), .wrst_o(wrst1), .rrst_o(rrst1),
        .oe_o(oe1), .rdclk_o(rdclk1), .pix_data_o(pd1), .pix_valid_o(pv1),
        .pix_x_o(px1), .pix_y_o(py1), .frame_ready_o(fr1), .frame_done_o(fd1),
        .busy_o(busy1), .led_o(led1)
    );

    // AL422 read-side model: pointer reset on rrst falling, next byte on rdclk rising.
    logic [7:0] ptr0 = 8'h00, ptr1 = 8'h00;
    logic rck0_p = 1'b0, rrst0_p = 1'b1, rck1_p = 1'b0, rrst1_p = 1'b1;
    always @(negedge clk) begin
        if (!rrst0 && rrst0_p) ptr0 = 8'h00;
        if (rdclk0 && !rck0_p) begin din0 = ptr0; ptr0 = ptr0 + 8'h01; end
        rck0_p = rdclk0; rrst0_p = rrst0;
        if (!rrst1 && rrst1_p) ptr1 = 8'h00;
        if (rdclk1 && !rck1_p) begin din1 = ptr1; ptr1 = ptr1 + 8'h01; end
        rck1_p = rdclk1; rrst1_p = rrst1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_pv0(output int n);
        n = 0;
        do begin tick(); n++; end while (!pv0 && n < 64);
    endtask

    task automatic wait_pv1(output int n);
        n = 0;
        do begin tick(); n++; end while (!pv1 && n < 64);
    endtask

    // Full readout on dut0; optionally pulse takepicture mid-READ (must be ignored).
    task automatic readout0(input bit inject_tp);
        int n;
        int exp_gap;
        leer0 = 1'b1; tick(); leer0 = 1'b0;
        chk("rrst_low", rrst0, 1'b0);
        chk("rrst_oe", oe0, 1'b1);
        chk("rrst_busy", busy0, 1'b1);
        tick();
        chk("rdclk_low", rdclk0, 1'b0);
        tick();
        chk("rdclk_rise", rdclk0, 1'b1);
        exp_gap = 15;
        for (int k = 0; k < 8; k++) begin
            wait_pv0(n);
            chk("pix_gap", n, exp_gap);
            chk("pix_data", pd0, {8'(2 + 2 * k), 8'(3 + 2 * k)});
            chk("pix_x", px0, k % 4);
            chk("pix_y", py0, k / 4);
            chk("pix_fd", fd0, 1'b0);
            exp_gap = 8;
            if (k == 0) begin
                chk("read_oe", oe0, 1'b0);
                chk("read_rrst", rrst0, 1'b1);
                if (inject_tp) begin
                    tp0 = 1'b1; tick(); tp0 = 1'b0;
                    exp_gap = 7;
                end
            end
        end
        tick();
        chk("fd_pulse", fd0, 1'b1);
        chk("fd_pv", pv0, 1'b0);
        chk("fd_oe", oe0, 1'b1);
        chk("fd_rdclk", rdclk0, 1'b0);
        chk("fd_busy", busy0, 1'b0);
        chk("fd_ready", fr0, 1'b1);
        tick();
        chk("fd_clear", fd0, 1'b0);
    endtask

    initial begin
        int n;
        ticks(3);
        chk("rst_we", we0, 1'b1);
        chk("rst_wrst", wrst0, 1'b1);
        chk("rst_rrst", rrst0, 1'b1);
        chk("rst_oe", oe0, 1'b1);
        chk("rst_rdclk", rdclk0, 1'b0);
        chk("rst_pd", pd0, 16'h0000);
        chk("rst_pv", pv0, 1'b0);
        chk("rst_px", px0, 2'd0);
        chk("rst_py", py0, 1'b0);
        chk("rst_fr", fr0, 1'b0);
        chk("rst_fd", fd0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_led", led0, 1'b1);
        reset = 1'b0;
        tick();
        chk("idle_led", led0, 1'b0);

        // leer with no frame captured is ignored
        leer0 = 1'b1; leer1 = 1'b1; tick(); leer0 = 1'b0; leer1 = 1'b0;
        ticks(3);
        chk("noframe_busy", busy0, 1'b0);
        chk("noframe_rrst", rrst0, 1'b1);
        chk("noframe_rdclk", rdclk0, 1'b0);
        chk("noframe_busy1", busy1, 1'b0);

        // capture on both instances from the same vsync pulses
        tp0 = 1'b1; tp1 = 1'b1; tick(); tp0 = 1'b0; tp1 = 1'b0;
        chk("arm_busy", busy0, 1'b1);
        chk("arm_wrst", wrst0, 1'b1);
        chk("arm_we", we0, 1'b1);
        vsync = 1'b1;
        ticks(2);
        chk("vs1_wrst_early", wrst0, 1'b1);
        tick();
        chk("vs1_wrst", wrst0, 1'b0);
        chk("vs1_we", we0, 1'b1);
        ticks(5);
        vsync = 1'b0;
        ticks(2);
        chk("vs1f_wrst_early", wrst0, 1'b0);
        chk("vs1f_we_early", we0, 1'b1);
        tick();
        chk("cap_wrst", wrst0, 1'b1);
        chk("cap_we", we0, 1'b0);
        chk("cap_led", led0, 1'b1);
        ticks(20);
        chk("cap_we_hold", we0, 1'b0);
        vsync = 1'b1;
        ticks(2);
        chk("vs2_we_early", we0, 1'b0);
        chk("vs2_fr_early", fr0, 1'b0);
        tick();
        chk("stored_we", we0, 1'b1);
        chk("stored_fr", fr0, 1'b1);
        chk("stored_busy", busy0, 1'b0);
        chk("stored_led", led0, 1'b0);
        chk("stored_fr1", fr1, 1'b1);
        ticks(4);
        vsync = 1'b0;
        ticks(4);

        readout0(1'b0);
        readout0(1'b1);

        // 1-byte-per-pixel instance: pixel equals one FIFO byte
        leer1 = 1'b1; tick(); leer1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            wait_pv1(n);
            chk("b1_gap", n, (k == 0) ? 13 : 4);
            chk("b1_data", pd1, 8'(2 + k));
            chk("b1_x", px1, k % 4);
            chk("b1_y", py1, k / 4);
        end
        tick();
        chk("b1_fd", fd1, 1'b1);
        chk("b1_oe", oe1, 1'b1);

        // reset in the middle of a readout
        leer0 = 1'b1; tick(); leer0 = 1'b0;
        wait_pv0(n);
        chk("mid_gap", n, 17);
        ticks(3);
        reset = 1'b1;
        tick();
        chk("mr_oe", oe0, 1'b1);
        chk("mr_rdclk", rdclk0, 1'b0);
        chk("mr_pv", pv0, 1'b0);
        chk("mr_fr", fr0, 1'b0);
        chk("mr_busy", busy0, 1'b0);
        chk("mr_rrst", rrst0, 1'b1);
        chk("mr_led", led0, 1'b1);
        reset = 1'b0;
        tick();
        chk("mr_led_rel", led0, 1'b0);
        leer0 = 1'b1; tick(); leer0 = 1'b0;
        ticks(4);
        chk("mr_leer_busy", busy0, 1'b0);
        chk("mr_leer_rrst", rrst0, 1'b1);
        chk("mr_leer_oe", oe0, 1'b1);
        chk("mr_leer_rdclk", rdclk0, 1'b0);
        chk("mr_leer_fr", fr0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
